// File: rtl/lcv_div_iter_del.sv
// Iterative radix-2 restoring divider, one division in flight.
// Operands are captured on accept, converted to magnitudes, divided over
// WIDTH iterations, sign-corrected, and the result is held until taken.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request, inp_ready high
// PREP   | operand magnitudes, result signs and divide-by-zero recorded
// CALC   | WIDTH shift/trial-subtract iterations
// FIX    | sign correction, result registers loaded, outp_valid raised
// DONE   | result held until outp_ready
module lcv_div_iter_del #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp_valid,
    output logic             inp_ready,
    input  logic             inp_signed,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    output logic             outp_valid,
    input  logic             outp_ready,
    output logic [WIDTH-1:0] outp_quot,
    output logic [WIDTH-1:0] outp_rem,
    output logic             outp_div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // quot_q holds the dividend on entry and shifts into the quotient
    logic [WIDTH-1:0] quot_q, quot_d;
    // bmag_q holds the raw divisor on entry, then its magnitude
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             sgn_q, sgn_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             inp_ready_q, inp_ready_d;
    logic             outp_valid_q, outp_valid_d;
    logic [WIDTH-1:0] outp_quot_q, outp_quot_d;
    logic [WIDTH-1:0] outp_rem_q, outp_rem_d;
    logic             outp_dz_q, outp_dz_d;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Operand signs only matter for signed requests.
    assign a_neg = sgn_q & quot_q[WIDTH-1];
    assign b_neg = sgn_q & bmag_q[WIDTH-1];

    // The partial remainder never reaches the divisor magnitude, so
    // WIDTH+1 bits hold both the shifted value and the trial difference.
    assign shifted = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, bmag_q};

    // Next-state and datapath for the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        quot_d       = quot_q;
        bmag_d       = bmag_q;
        rem_d        = rem_q;
        sgn_d        = sgn_q;
        neg_quot_d   = neg_quot_q;
        neg_rem_d    = neg_rem_q;
        dz_d         = dz_q;
        inp_ready_d  = inp_ready_q;
        outp_valid_d = outp_valid_q;
        outp_quot_d  = outp_quot_q;
        outp_rem_d   = outp_rem_q;
        outp_dz_d    = outp_dz_q;

        case (state_q)
            S_IDLE: begin
                if (inp_valid && inp_ready_q) begin
                    quot_d      = inp_a;
                    bmag_d      = inp_b;
                    sgn_d       = inp_signed;
                    inp_ready_d = 1'b0;
                    state_d     = S_PREP;
                end
            end
            S_PREP: begin
                quot_d    = a_neg ? (~quot_q + 1'b1) : quot_q;
                bmag_d    = b_neg ? (~bmag_q + 1'b1) : bmag_q;
                dz_d      = (bmag_q == '0);
                // Divide-by-zero keeps the all-ones quotient unnegated;
                // the remainder negation still restores the dividend.
                neg_quot_d = (a_neg ^ b_neg) & (bmag_q != '0);
                neg_rem_d  = a_neg;
                rem_d     = '0;
                cnt_d     = CW'(WIDTH - 1);
                state_d   = S_CALC;
            end
            S_CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d  = trial;
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = shifted;
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                outp_quot_d  = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
                outp_rem_d   = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1)
                                         : rem_q[WIDTH-1:0];
                outp_dz_d    = dz_q;
                outp_valid_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (outp_ready) begin
                    outp_valid_d = 1'b0;
                    inp_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                outp_valid_d = 1'b0;
                inp_ready_d  = 1'b1;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            quot_q       <= '0;
            bmag_q       <= '0;
            rem_q        <= '0;
            sgn_q        <= 1'b0;
            neg_quot_q   <= 1'b0;
            neg_rem_q    <= 1'b0;
            dz_q         <= 1'b0;
            inp_ready_q  <= 1'b1;
            outp_valid_q <= 1'b0;
            outp_quot_q  <= '0;
            outp_rem_q   <= '0;
            outp_dz_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            quot_q       <= quot_d;
            bmag_q       <= bmag_d;
            rem_q        <= rem_d;
            sgn_q        <= sgn_d;
            neg_quot_q   <= neg_quot_d;
            neg_rem_q    <= neg_rem_d;
            dz_q         <= dz_d;
            inp_ready_q  <= inp_ready_d;
            outp_valid_q <= outp_valid_d;
            outp_quot_q  <= outp_quot_d;
            outp_rem_q   <= outp_rem_d;
            outp_dz_q    <= outp_dz_d;
        end
    end

    assign inp_ready     = inp_ready_q;
    assign outp_valid    = outp_valid_q;
    assign outp_quot     = outp_quot_q;
    assign outp_rem      = outp_rem_q;
    assign outp_div_zero = outp_dz_q;

endmodule

// File: tb/tb_lcv_div_iter_del.sv
// Scoreboard bench for lcv_div_iter_del (WIDTH=32): directed vectors with
// hand-computed results, backpressure, mid-operation reset and a short
// model-checked random mix.
`timescale 1ns/1ps
module tb_lcv_div_iter_del;

    logic        clk;
    logic        rst;
    logic        inp_valid;
    logic        inp_ready;
    logic        inp_signed;
    logic [31:0] inp_a;
    logic [31:0] inp_b;
    logic        outp_valid;
    logic        outp_ready;
    logic [31:0] outp_quot;
    logic [31:0] outp_rem;
    logic        outp_div_zero;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];

    int s_checks = 0;
    int s_fails  = 0;
    int m_checks = 0;
    int m_fails  = 0;

    lcv_div_iter_del #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .inp_valid     (inp_valid),
        .inp_ready     (inp_ready),
        .inp_signed    (inp_signed),
        .inp_a         (inp_a),
        .inp_b         (inp_b),
        .outp_valid    (outp_valid),
        .outp_ready    (outp_ready),
        .outp_quot     (outp_quot),
        .outp_rem      (outp_rem),
        .outp_div_zero (outp_div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: compares a result in the cycle its handshake completes.
    always @(negedge clk) begin
        exp_t e;
        if (rst && outp_valid) begin
            if (exp_q.size() == 0) begin
                m_checks++;
                m_fails++;
                $display("FAIL unexpected_result quot=%h rem=%h dz=%b (none expected)",
                         outp_quot, outp_rem, outp_div_zero);
            end else if (outp_ready) begin
                e = exp_q.pop_front();
                m_checks++;
                if (outp_quot !== e.q || outp_rem !== e.r || outp_div_zero !== e.dz) begin
                    m_fails++;
                    $display("FAIL %s: got quot=%h rem=%h dz=%b, expected quot=%h rem=%h dz=%b",
                             e.name, outp_quot, outp_rem, outp_div_zero, e.q, e.r, e.dz);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        s_checks++;
        if (got !== exp) begin
            s_fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic send(input string nm, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input logic ed, input bit push);
        int   n;
        exp_t e;
        n = 0;
        while (!inp_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!inp_ready) begin
            s_checks++;
            s_fails++;
            $display("FAIL %s_accept_timeout: inp_ready stayed low for %0d cycles", nm, n);
        end
        inp_valid  = 1'b1;
        inp_signed = s;
        inp_a      = a;
        inp_b      = b;
        if (push) begin
            e.name = nm;
            e.q    = eq;
            e.r    = er;
            e.dz   = ed;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        inp_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || outp_valid) && n < 500) begin
            outp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        outp_ready = 1'b1;
        if (exp_q.size() != 0 || outp_valid) begin
            s_checks++;
            s_fails++;
            $display("FAIL drain_timeout: %0d results outstanding, outp_valid=%b",
                     exp_q.size(), outp_valid);
            exp_q.delete();
        end
    endtask

    function automatic exp_t ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.name = "random";
        e.dz   = 1'b0;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a;
            e.r = 32'd0;
        end else begin
            e.q = 32'($signed(a) / $signed(b));
            e.r = 32'($signed(a) % $signed(b));
        end
        return e;
    endfunction

    initial begin
        int   k;
        int   saw;
        logic [31:0] hq, hr;
        logic        hd;
        logic        rs;
        logic [31:0] ra, rb;
        exp_t        e;

        rst        = 1'b0;
        inp_valid  = 1'b0;
        inp_signed = 1'b0;
        inp_a      = 32'd0;
        inp_b      = 32'd0;
        outp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_inp_ready", 32'(inp_ready), 32'd1);
        chk("reset_outp_valid", 32'(outp_valid), 32'd0);
        chk("reset_quot", outp_quot, 32'd0);
        chk("reset_rem", outp_rem, 32'd0);
        chk("reset_div_zero", 32'(outp_div_zero), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Latency and ready turnaround on 100/7.
        send("u_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        chk("busy_inp_ready", 32'(inp_ready), 32'd0);
        k = 1;
        while (!outp_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency_edges", 32'(k), 32'd35);
        @(posedge clk); #1;
        chk("post_hs_outp_valid", 32'(outp_valid), 32'd0);
        chk("post_hs_inp_ready", 32'(inp_ready), 32'd1);
        drain(1'b0);

        // Directed sign, zero and overflow cases.
        send("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain(1'b0);
        send("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);
        drain(1'b0);
        send("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b1);
        drain(1'b0);
        send("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b1);
        drain(1'b0);
        send("u_div0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
        drain(1'b0);
        send("s_div0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
        drain(1'b0);
        send("s_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        drain(1'b0);
        send("s_zero_dividend", 1'b1, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1);
        drain(1'b0);
        send("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        drain(1'b0);

        // Backpressure: result held, second request ignored until released.
        outp_ready = 1'b0;
        send("bp_first", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1);
        k = 0;
        while (!outp_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("bp_valid_seen", 32'(outp_valid), 32'd1);
        hq = outp_quot;
        hr = outp_rem;
        hd = outp_div_zero;
        inp_valid  = 1'b1;
        inp_signed = 1'b1;
        inp_a      = 32'hFFFF_FC18;
        inp_b      = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", 32'(outp_valid), 32'd1);
            chk("bp_quot_hold", outp_quot, hq);
            chk("bp_rem_hold", outp_rem, hr);
            chk("bp_dz_hold", 32'(outp_div_zero), 32'(hd));
            chk("bp_inp_ready_low", 32'(inp_ready), 32'd0);
        end
        inp_valid  = 1'b0;
        outp_ready = 1'b1;
        drain(1'b0);
        send("bp_second", 1'b1, 32'hFFFF_FC18, 32'd3, 32'hFFFF_FEB3, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain(1'b0);

        // Reset during CALC iteration 10: nothing may come out.
        send("rst_discarded", 1'b0, 32'd12345, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_inp_ready", 32'(inp_ready), 32'd1);
        chk("midrst_outp_valid", 32'(outp_valid), 32'd0);
        chk("midrst_quot", outp_quot, 32'd0);
        chk("midrst_rem", outp_rem, 32'd0);
        saw = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (outp_valid) saw++;
        end
        chk("midrst_no_result", 32'(saw), 32'd0);
        send("after_rst_1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);
        drain(1'b0);

        // Random mix against the reference model, with random output stalls.
        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom_range(0, 15);
                1: rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                2: rb = 32'($urandom) >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            e = ref_div(rs, ra, rb);
            send("random", rs, ra, rb, e.q, e.r, e.dz, 1'b1);
            drain(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", s_checks + m_checks, s_fails + m_fails);
        $finish;
    end

endmodule
